sp_ram_arbiter: RTL and testbench

Two-requester round-robin arbiter and access sequencer for the single-port parity RAM (16-bit data, 10-bit address, 1024 words). It accepts read/write requests from two clients and serialises them onto the RAM's `din`/`addr`/`wr_en`/`rd_en`/`blk_sel` pins. It returns read data plus the RAM's parity bit to the owning client. It sits between the two bus clients and the RAM instance and is the only driver of the RAM control pins.

---
 rtl/sp_ram_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_sp_ram_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_arbiter.sv
// sp_ram_arbiter
// Two-client round-robin arbiter and access sequencer for the single-port
// parity RAM. One access is outstanding at a time: a request is latched in
// IDLE, put on the RAM pins for exactly one ACCESS cycle, and reads then wait
// RD_LAT cycles before the RAM data and parity are captured and handed back.
module sp_ram_arbiter #(
    parameter int ADD_SIZE  = 10,
    parameter int MEM_WIDTH = 16,
    parameter int RD_LAT    = 1   // 1..4 cycles from rd_en to valid mem_dout
) (
    input  logic                 clk,
    input  logic                 rst,            // asynchronous, active-low

    // client 0
    input  logic                 req0,
    input  logic                 we0,
    input  logic [ADD_SIZE-1:0]  addr0,
    input  logic [MEM_WIDTH-1:0] wdata0,
    output logic                 gnt0,
    output logic                 rvalid0,

    // client 1
    input  logic                 req1,
    input  logic                 we1,
    input  logic [ADD_SIZE-1:0]  addr1,
    input  logic [MEM_WIDTH-1:0] wdata1,
    output logic                 gnt1,
    output logic                 rvalid1,

    // shared read return
    output logic [MEM_WIDTH-1:0] rdata,
    output logic                 rpar,
    output logic                 busy,

    // RAM pins
    output logic                 mem_blk_sel,
    output logic                 mem_wr_en,
    output logic                 mem_rd_en,
    output logic                 mem_addr_en,
    output logic                 mem_dout_en,
    output logic [ADD_SIZE-1:0]  mem_addr,
    output logic [MEM_WIDTH-1:0] mem_din,
    input  logic [MEM_WIDTH-1:0] mem_dout,
    input  logic                 mem_parity_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RD_WAIT = 2'd2,
        RD_CAP  = 2'd3
    } state_t;

    // Wait counter is loaded with RD_LAT-1; two bits cover RD_LAT up to 4.
    localparam logic [1:0] CNT_LOAD = 2'(RD_LAT - 1);

    state_t               state_q, state_d;
    logic                 owner_q, owner_d;          // client owning the current access
    logic                 last_owner_q, last_owner_d; // client granted most recently
    logic                 we_q, we_d;
    logic [ADD_SIZE-1:0]  addr_q, addr_d;
    logic [MEM_WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [MEM_WIDTH-1:0] rdata_q, rdata_d;
    logic                 rpar_q, rpar_d;

    // Arbitration choice for a request seen in IDLE: a tie goes to the client
    // that did not win last; a lone request wins regardless of history.
    logic pick;
    assign pick = (req0 && req1) ? ~last_owner_q : req1;

    // Next-state and datapath update for the access sequencer.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        rpar_d       = rpar_q;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d = pick;
                    we_d    = pick ? we1    : we0;
                    addr_d  = pick ? addr1  : addr0;
                    wdata_d = pick ? wdata1 : wdata0;
                    state_d = ACCESS;
                end
            end

            ACCESS: begin
                last_owner_d = owner_q;
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = RD_WAIT;
                end
            end

            RD_WAIT: begin
                if (cnt_q == 2'd0) begin
                    // Last wait cycle: RAM output is valid now.
                    rdata_d = mem_dout;
                    rpar_d  = mem_parity_out;
                    state_d = RD_CAP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end

            RD_CAP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched command and read-return registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;   // client 0 wins the first tie
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= 2'd0;
            rdata_q      <= '0;
            rpar_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            rpar_q       <= rpar_d;
        end
    end

    // Output decode: only registered state and the latched command, never the
    // live request inputs, so the RAM pins and grants are glitch-free.
    logic in_access;
    assign in_access = (state_q == ACCESS);

    assign gnt0    = in_access && !owner_q;
    assign gnt1    = in_access &&  owner_q;
    assign rvalid0 = (state_q == RD_CAP) && !owner_q;
    assign rvalid1 = (state_q == RD_CAP) &&  owner_q;
    assign busy    = (state_q != IDLE);

    assign rdata = rdata_q;
    assign rpar  = rpar_q;

    assign mem_blk_sel = in_access;
    assign mem_wr_en   = in_access &&  we_q;
    assign mem_rd_en   = in_access && !we_q;
    // RAM input/output registers are bypassed; read latency is RD_LAT.
    assign mem_addr_en = 1'b0;
    assign mem_dout_en = 1'b0;
    // Address and write data follow the latched command, so they hold their
    // last value outside ACCESS.
    assign mem_addr    = addr_q;
    assign mem_din     = wdata_q;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed self-checking bench for sp_ram_arbiter. Instance A uses RD_LAT=1
// with a behavioural RAM; instance B uses RD_LAT=3 with an address-derived
// read pattern (data = addr + 1).
module tb_sp_ram_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- instance A (RD_LAT = 1) ----------------
    logic        req0, req1, we0, we1;
    logic [9:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, rpar, busy;
    logic [15:0] rdata;
    logic        mem_blk_sel, mem_wr_en, mem_rd_en, mem_addr_en, mem_dout_en;
    logic [9:0]  mem_addr;
    logic [15:0] mem_din, mem_dout;
    logic        mem_parity_out;

    sp_ram_arbiter #(.ADD_SIZE(10), .MEM_WIDTH(16), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
        .rdata(rdata), .rpar(rpar), .busy(busy),
        .mem_blk_sel(mem_blk_sel), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_addr_en(mem_addr_en), .mem_dout_en(mem_dout_en),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_parity_out(mem_parity_out)
    );

    // RAM model A: one-cycle read; non-read cycles present a junk word so a
    // capture on the wrong cycle is visible.
    logic [15:0] ram_a [0:1023];
    logic [15:0] rd_pipe_a = 16'hDEAD;
    always @(posedge clk) begin
        if (mem_blk_sel && mem_wr_en) ram_a[mem_addr] <= mem_din;
        rd_pipe_a <= (mem_blk_sel && mem_rd_en) ? ram_a[mem_addr] : 16'hDEAD;
    end
    assign mem_dout       = rd_pipe_a;
    assign mem_parity_out = ^rd_pipe_a;

    // ---------------- instance B (RD_LAT = 3) ----------------
    logic        req0_b, req1_b, we0_b, we1_b;
    logic [9:0]  addr0_b, addr1_b;
    logic [15:0] wdata0_b, wdata1_b;
    logic        gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, rpar_b, busy_b;
    logic [15:0] rdata_b;
    logic        mem_blk_sel_b, mem_wr_en_b, mem_rd_en_b, mem_addr_en_b, mem_dout_en_b;
    logic [9:0]  mem_addr_b;
    logic [15:0] mem_din_b, mem_dout_b;
    logic        mem_parity_out_b;

    sp_ram_arbiter #(.ADD_SIZE(10), .MEM_WIDTH(16), .RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst),
        .req0(req0_b), .we0(we0_b), .addr0(addr0_b), .wdata0(wdata0_b), .gnt0(gnt0_b), .rvalid0(rvalid0_b),
        .req1(req1_b), .we1(we1_b), .addr1(addr1_b), .wdata1(wdata1_b), .gnt1(gnt1_b), .rvalid1(rvalid1_b),
        .rdata(rdata_b), .rpar(rpar_b), .busy(busy_b),
        .mem_blk_sel(mem_blk_sel_b), .mem_wr_en(mem_wr_en_b), .mem_rd_en(mem_rd_en_b),
        .mem_addr_en(mem_addr_en_b), .mem_dout_en(mem_dout_en_b),
        .mem_addr(mem_addr_b), .mem_din(mem_din_b), .mem_dout(mem_dout_b),
        .mem_parity_out(mem_parity_out_b)
    );

    // RAM model B: three-stage read pipe, content = address + 1.
    logic [15:0] pipe_b0 = 16'hDEAD, pipe_b1 = 16'hDEAD, pipe_b2 = 16'hDEAD;
    always @(posedge clk) begin
        pipe_b0 <= (mem_blk_sel_b && mem_rd_en_b) ? (16'(mem_addr_b) + 16'd1) : 16'hDEAD;
        pipe_b1 <= pipe_b0;
        pipe_b2 <= pipe_b1;
    end
    assign mem_dout_b       = pipe_b2;
    assign mem_parity_out_b = ^pipe_b2;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        req0_b = 0; req1_b = 0; we0_b = 0; we1_b = 0; addr0_b = '0; addr1_b = '0;
        wdata0_b = '0; wdata1_b = '0;

        // ---- reset values ----
        #12;
        check("rst_ctrl_a", 32'({gnt0, gnt1, rvalid0, rvalid1, rpar, busy, mem_blk_sel,
                                 mem_wr_en, mem_rd_en, mem_addr_en, mem_dout_en}), 32'h0);
        check("rst_data_a", 32'({rdata, mem_din}), 32'h0);
        check("rst_addr_a", 32'(mem_addr), 32'h0);
        check("rst_ctrl_b", 32'({gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, rpar_b, busy_b,
                                 mem_blk_sel_b, mem_wr_en_b, mem_rd_en_b}), 32'h0);
        rst = 1;
        tick();

        // ---- single write: client 0, A5A5 -> 3FF ----
        req0 = 1; we0 = 1; addr0 = 10'h3FF; wdata0 = 16'hA5A5;
        tick();
        check("wr_gnt", 32'({gnt0, gnt1}), 32'b10);
        check("wr_ctrl", 32'({mem_blk_sel, mem_wr_en, mem_rd_en, busy}), 32'b1101);
        check("wr_addr", 32'(mem_addr), 32'h3FF);
        check("wr_din", 32'(mem_din), 32'hA5A5);
        req0 = 0;
        tick();
        check("wr_idle", 32'({gnt0, busy, mem_blk_sel, mem_wr_en}), 32'b0000);
        check("wr_addr_hold", 32'(mem_addr), 32'h3FF);

        // ---- read back 3FF ----
        we0 = 0;
        req0 = 1;
        tick();
        check("rd_gnt", 32'({gnt0, gnt1}), 32'b10);
        check("rd_ctrl", 32'({mem_blk_sel, mem_rd_en, mem_wr_en}), 32'b110);
        req0 = 0;
        tick();
        check("rd_wait", 32'({busy, rvalid0, rvalid1, mem_blk_sel}), 32'b1000);
        tick();
        check("rd_rvalid", 32'({rvalid0, rvalid1, busy}), 32'b101);
        check("rd_rdata", 32'(rdata), 32'hA5A5);
        check("rd_rpar", 32'(rpar), 32'h0);
        tick();
        check("rd_done", 32'({rvalid0, rvalid1, busy}), 32'b000);
        check("rd_hold", 32'(rdata), 32'hA5A5);

        // ---- request from client 1 while client 0 read is in flight ----
        req0 = 1; we0 = 0; addr0 = 10'h3FF;
        tick();
        check("bz_gnt0", 32'({gnt0, gnt1}), 32'b10);
        req0 = 0;
        tick();
        req1 = 1; we1 = 1; addr1 = 10'h155; wdata1 = 16'h1234;
        check("bz_wait", 32'({gnt1, busy}), 32'b01);
        tick();
        check("bz_cap", 32'({rvalid0, gnt1}), 32'b10);
        tick();
        check("bz_idle", 32'({gnt1, busy}), 32'b00);
        tick();
        check("bz_gnt1", 32'({gnt0, gnt1, mem_wr_en}), 32'b011);
        check("bz_addr", 32'({mem_addr, mem_din}), 32'({10'h155, 16'h1234}));
        req1 = 0;
        tick();
        check("bz_after", 32'({gnt0, gnt1}), 32'b00);
        tick();
        check("bz_no_regrant", 32'({gnt0, gnt1, busy}), 32'b000);

        // ---- reset in the middle of a read ----
        req0 = 1; we0 = 0; addr0 = 10'h155;
        tick();
        req0 = 0;
        tick();
        check("mr_in_wait", 32'(busy), 32'h1);
        rst = 0;
        #1;
        check("mr_ctrl", 32'({gnt0, gnt1, rvalid0, rvalid1, rpar, busy, mem_blk_sel,
                              mem_wr_en, mem_rd_en}), 32'h0);
        check("mr_data", 32'({rdata, mem_din}), 32'h0);
        check("mr_addr", 32'(mem_addr), 32'h0);
        #2;
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mr_no_rvalid", 32'({rvalid0, rvalid1, busy}), 32'b000);
        end

        // ---- ties after reset: client 0 first ----
        req0 = 1; we0 = 1; addr0 = 10'h010; wdata0 = 16'h1111;
        req1 = 1; we1 = 1; addr1 = 10'h020; wdata1 = 16'h2222;
        tick();
        check("tie1_first", 32'({gnt0, gnt1}), 32'b10);
        check("tie1_addr", 32'(mem_addr), 32'h010);
        req0 = 0;
        tick();
        check("tie1_idle", 32'({gnt0, gnt1}), 32'b00);
        tick();
        check("tie1_second", 32'({gnt0, gnt1}), 32'b01);
        check("tie1_addr2", 32'(mem_addr), 32'h020);
        req1 = 0;
        tick();
        // lone client 0 wins although it did not win last time... client 1 did
        req0 = 1;
        tick();
        check("solo0", 32'({gnt0, gnt1}), 32'b10);
        req0 = 0;
        tick();
        // tie again: client 0 won last, so client 1 goes first
        req0 = 1; req1 = 1;
        tick();
        check("tie2_first", 32'({gnt0, gnt1}), 32'b01);
        req1 = 0;
        tick();
        tick();
        check("tie2_second", 32'({gnt0, gnt1}), 32'b10);
        req0 = 0;
        tick();

        // ---- continuous contention from reset: 20 accesses ----
        rst = 0;
        #2;
        rst = 1;
        req0 = 1; we0 = 1; addr0 = 10'h001; wdata0 = 16'hAAAA;
        req1 = 1; we1 = 1; addr1 = 10'h002; wdata1 = 16'h5555;
        begin
            logic exp_owner;
            exp_owner = 1'b0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (i % 2 == 0) begin
                    check("cont_access", 32'({gnt0, gnt1, mem_blk_sel, mem_wr_en}),
                          exp_owner ? 32'b0111 : 32'b1011);
                    exp_owner = ~exp_owner;
                end else begin
                    check("cont_idle", 32'({gnt0, gnt1, mem_blk_sel, mem_wr_en}), 32'b0000);
                end
            end
        end
        req0 = 0; req1 = 0;
        tick();
        tick();
        check("cont_quiet", 32'({gnt0, gnt1, busy}), 32'b000);

        // ---- RD_LAT = 3: client 1 reads address 0 (data 0001) ----
        req1_b = 1; we1_b = 0; addr1_b = 10'h000;
        tick();
        check("lat_gnt", 32'({gnt0_b, gnt1_b, mem_rd_en_b}), 32'b011);
        req1_b = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lat_wait", 32'({rvalid0_b, rvalid1_b, busy_b}), 32'b001);
        end
        tick();
        check("lat_rvalid", 32'({rvalid0_b, rvalid1_b}), 32'b01);
        check("lat_rdata", 32'(rdata_b), 32'h0001);
        check("lat_rpar", 32'(rpar_b), 32'h1);
        tick();
        check("lat_done", 32'({rvalid1_b, busy_b}), 32'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
